// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op units and the result unpacker.
package logic_op_pkg;
    localparam int RESULT_W  = 32;
    localparam int OPERAND_W = 16;

    typedef enum logic [1:0] {IDLE, LO, HI} unpack_state_t;
endpackage

// File: rtl/result_fifo.sv
// Circular buffer of result words; exposes the head word, the entry behind it, and the fill count.
module result_fifo
    import logic_op_pkg::*;
#(
    parameter int W     = RESULT_W,
    parameter int NW    = W,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  pushData,
    output logic [W-1:0]  head,
    output logic [NW-1:0] headNext,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign head     = mem[rdPtr];
    assign headNext = mem[rdPtr + PW'(1)][NW-1:0];
endmodule

// File: rtl/result_unpacker.sv
// Splits buffered 32-bit result words into 16-bit beats, low half first.
// RESULT_UNPACKER_SKIP_ZERO_HI_EN: words with a zero high half are sent as a single beat.
//
// state | meaning
// IDLE  | nothing presented, buffer empty
// LO    | presenting low half of the head word
// HI    | presenting high half of the head word (final beat)
module result_unpacker
    import logic_op_pkg::*;
#(
    parameter int IN_W  = RESULT_W,
    parameter int OUT_W = OPERAND_W,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CW-1:0]    pending
);
`ifdef RESULT_UNPACKER_SKIP_ZERO_HI_EN
    localparam int PEEK_W = IN_W;
`else
    localparam int PEEK_W = OUT_W;
`endif

    unpack_state_t     state;
    logic [IN_W-1:0]   head;
    logic [PEEK_W-1:0] headNext;
    logic [PEEK_W-1:0] nextWord;
    logic [CW-1:0]     count;
    logic [CW-1:0]     countAfter;
    logic              push;
    logic              pop;
    logic              loadWord;
    logic              nextLast;

    result_fifo #(
        .W     (IN_W),
        .NW    (PEEK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .pushData (in_data),
        .head     (head),
        .headNext (headNext),
        .count    (count)
    );

    // in_ready looks only at the registered count, never at out_ready
    assign in_ready   = !rst && (count != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready && out_last;
    assign countAfter = count + CW'(push) - CW'(pop);
    assign pending    = count;

    // Pick the word that becomes the new LO beat; a same-cycle push wins when nothing else is queued
    always_comb begin
        nextWord = in_data[PEEK_W-1:0];
        loadWord = 1'b0;
        if (state == IDLE) begin
            loadWord = (count != '0) || push;
            if (count != '0) nextWord = head[PEEK_W-1:0];
        end else if (pop) begin
            loadWord = (countAfter != '0);
            if (count > CW'(1)) nextWord = headNext;
        end
`ifdef RESULT_UNPACKER_SKIP_ZERO_HI_EN
        nextLast = (nextWord[IN_W-1:OUT_W] == '0);
`else
        nextLast = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (loadWord) begin
                        state     <= LO;
                        out_valid <= 1'b1;
                        out_data  <= nextWord[OUT_W-1:0];
                        out_last  <= nextLast;
                    end
                end
                LO, HI: begin
                    if (out_ready) begin
                        if (!out_last) begin
                            state    <= HI;
                            out_data <= head[IN_W-1:OUT_W];
                            out_last <= 1'b1;
                        end else if (loadWord) begin
                            state     <= LO;
                            out_valid <= 1'b1;
                            out_data  <= nextWord[OUT_W-1:0];
                            out_last  <= nextLast;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_unpacker.sv
// Self-checking bench for result_unpacker: vector table, hand-written corner sequences, randomized run against a beat-queue model.
module tb_result_unpacker;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  pending;

    result_unpacker #(.IN_W(32), .OUT_W(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef RESULT_UNPACKER_SKIP_ZERO_HI_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // Model: the sequence of beats still owed downstream
    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;
    beat_t beatQ[$];
    bit    modelLive = 1'b0;

    function automatic int wordsHeld();
        int n = 0;
        foreach (beatQ[i]) if (beatQ[i].last) n++;
        return n;
    endfunction

    task automatic modelPush(input logic [31:0] w);
        beat_t b;
        if (SKIP && w[31:16] == 16'h0) begin
            b.data = w[15:0]; b.last = 1'b1; beatQ.push_back(b);
        end else begin
            b.data = w[15:0];  b.last = 1'b0; beatQ.push_back(b);
            b.data = w[31:16]; b.last = 1'b1; beatQ.push_back(b);
        end
    endtask

    task automatic apply(input logic r, input logic iv, input logic [31:0] id, input logic ordy);
        rst = r; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
    endtask

    // Compare against the model, let the edge happen, then move the model across it
    task automatic advance();
        logic expRdy;
        logic doPush;
        logic doPop;
        expRdy = !rst && (wordsHeld() != DEPTH);
        if (modelLive) begin
            chk("in_ready", 32'(in_ready), 32'(expRdy));
            chk("pending", 32'(pending), 32'(wordsHeld()));
            chk("out_valid", 32'(out_valid), 32'(beatQ.size() != 0));
            if (beatQ.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(beatQ[0].data));
                chk("out_last", 32'(out_last), 32'(beatQ[0].last));
            end
        end
        doPush = in_valid && expRdy;
        doPop  = (beatQ.size() != 0) && out_ready;
        @(negedge clk);
        if (rst) begin
            beatQ.delete();
        end else begin
            if (doPop) void'(beatQ.pop_front());
            if (doPush) modelPush(in_data);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        eRdy;
        logic        eVal;
        logic [15:0] eData;
        logic        eLast;
        logic [1:0]  ePend;
    } vec_t;
    vec_t tbl[17];

    initial begin
        // back-to-back words, full stream
        tbl[0]  = '{1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 32'h9ABC_DEF0, 1'b1, 1'b1, 1'b1, 16'h5678, 1'b0, 2'd1};
        tbl[2]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 2'd2};
        tbl[3]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 16'hDEF0, 1'b0, 2'd1};
        tbl[4]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 16'h9ABC, 1'b1, 2'd1};
        tbl[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0};
        // stalled output, buffer fills, then full-buffer pop with in_valid held high
        tbl[6]  = '{1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[7]  = '{1'b1, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b1, 16'h5678, 1'b0, 2'd1};
        tbl[8]  = '{1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b0, 2'd2};
        tbl[9]  = '{1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b0, 2'd2};
        tbl[10] = '{1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1, 16'h5678, 1'b0, 2'd2};
        tbl[11] = '{1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 2'd2};
        tbl[12] = '{1'b1, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1, 16'hDEF0, 1'b0, 2'd1};
        tbl[13] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16'h9ABC, 1'b1, 2'd2};
        tbl[14] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 16'hF00D, 1'b0, 2'd1};
        tbl[15] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 16'h0BAD, 1'b1, 2'd1};
        tbl[16] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0};

        // reset
        apply(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready_held", 32'(in_ready), 32'd0);
        @(negedge clk);
        modelLive = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply(1'b0, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("t%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].eRdy));
            chk($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eVal));
            chk($sformatf("t%0d_out_data", i), 32'(out_data), 32'(tbl[i].eData));
            chk($sformatf("t%0d_out_last", i), 32'(out_last), 32'(tbl[i].eLast));
            chk($sformatf("t%0d_pending", i), 32'(pending), 32'(tbl[i].ePend));
            advance();
        end

        // single word with zero high half
        apply(1'b0, 1'b1, 32'h0000_FFFF, 1'b1);
        advance();
        apply(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        chk("single_lo_valid", 32'(out_valid), 32'd1);
        chk("single_lo_data", 32'(out_data), 32'h0000_FFFF);
        chk("single_lo_last", 32'(out_last), 32'(SKIP));
        advance();
`ifndef RESULT_UNPACKER_SKIP_ZERO_HI_EN
        apply(1'b0, 1'b0, 32'h0, 1'b1);
        chk("single_hi_data", 32'(out_data), 32'h0000_0000);
        chk("single_hi_last", 32'(out_last), 32'd1);
        advance();
`endif
        apply(1'b0, 1'b0, 32'h0, 1'b1);
        chk("single_idle_valid", 32'(out_valid), 32'd0);
        chk("single_idle_pending", 32'(pending), 32'd0);
        advance();

        // reset while the high half is presented
        apply(1'b0, 1'b1, 32'hAAAA_5555, 1'b1);
        advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mid_lo_data", 32'(out_data), 32'h5555);
        advance();
        apply(1'b1, 1'b0, 32'h0, 1'b0);
        chk("mid_hi_data", 32'(out_data), 32'hAAAA);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        advance();
        apply(1'b1, 1'b0, 32'h0, 1'b1);
        chk("mid_after_valid", 32'(out_valid), 32'd0);
        chk("mid_after_pending", 32'(pending), 32'd0);
        chk("mid_after_in_ready", 32'(in_ready), 32'd0);
        advance();
        apply(1'b0, 1'b1, 32'h0001_0002, 1'b1);
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mid_w_lo", 32'(out_data), 32'h0002);
        chk("mid_w_lo_last", 32'(out_last), 32'd0);
        advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mid_w_hi", 32'(out_data), 32'h0001);
        chk("mid_w_hi_last", 32'(out_last), 32'd1);
        advance();

        // randomized traffic against the beat-queue model
        for (int n = 0; n < 4000; n++) begin
            logic        r;
            logic        iv;
            logic [31:0] w;
            logic        ordy;
            r    = ($urandom_range(0, 199) == 0);
            iv   = ($urandom_range(0, 2) != 0);
            w    = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:16] = 16'h0;
            ordy = ($urandom_range(0, 3) != 0);
            apply(r, iv, w, ordy);
            advance();
        end

        for (int n = 0; n < 8; n++) begin
            apply(1'b0, 1'b0, $urandom, 1'b1);
            advance();
        end
        chk("drain_empty", 32'(beatQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
